// File: rtl/led_breath_scheduler.sv
// Breathing-envelope PWM sequencer for a bank of LEDs: unison, chase and note-flash patterns.
// Optional build macro LED_ACTIVE_LOW_EN inverts the LED outputs (idle/reset value all ones).
module led_breath_scheduler #(
  parameter int N_LED        = 8,
  parameter int PERIOD       = 10000,
  parameter int DUTY_MAX     = 9999,
  parameter int DUTY_STEP    = 1,
  parameter int HOLD_PERIODS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     note_valid,
  input  logic [$clog2(N_LED)-1:0] note_idx,
  output logic [N_LED-1:0]         leds,
  output logic                     period_tick,
  output logic                     busy
);

  localparam int CNT_W  = $clog2(PERIOD);
  localparam int DUTY_W = $clog2(DUTY_MAX + 1);
  localparam int CH_W   = $clog2(N_LED);
  localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RISE    = 3'd1;
  localparam logic [2:0] S_HOLD_HI = 3'd2;
  localparam logic [2:0] S_FALL    = 3'd3;
  localparam logic [2:0] S_HOLD_LO = 3'd4;

  localparam logic [1:0] M_OFF    = 2'b00;
  localparam logic [1:0] M_UNISON = 2'b01;
  localparam logic [1:0] M_CHASE  = 2'b10;
  localparam logic [1:0] M_NOTE   = 2'b11;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [N_LED-1:0] OFF_VAL = '1;
`else
  localparam logic [N_LED-1:0] OFF_VAL = '0;
`endif

  logic [CNT_W-1:0]  r_cnt;
  logic [DUTY_W-1:0] r_duty;
  logic [CH_W-1:0]   r_ch;
  logic [HOLD_W-1:0] r_hold;
  logic [2:0]        r_state;
  logic [1:0]        r_mode;
  logic [N_LED-1:0]  r_leds;
  logic              r_period_tick;

  logic              w_force;
  logic              w_note;
  logic              w_on;
  logic              w_hold_done;
  logic [DUTY_W-1:0] w_duty_up;
  logic [DUTY_W-1:0] w_duty_dn;
  logic [CH_W-1:0]   w_ch_next;
  logic [N_LED-1:0]  w_pat;

  assign w_force = !en || (mode == M_OFF);
  assign w_note  = note_valid && (mode == M_NOTE) && (32'(note_idx) < 32'(N_LED));

  // Saturation is decided on 32-bit sums so a step past DUTY_MAX or below 0 never wraps.
  assign w_duty_up = (32'(r_duty) + 32'(DUTY_STEP) >= 32'(DUTY_MAX)) ?
                     DUTY_W'(DUTY_MAX) : r_duty + DUTY_W'(DUTY_STEP);
  assign w_duty_dn = (32'(r_duty) <= 32'(DUTY_STEP)) ? '0 : r_duty - DUTY_W'(DUTY_STEP);

  assign w_ch_next   = (32'(r_ch) == 32'(N_LED - 1)) ? '0 : r_ch + CH_W'(1);
  assign w_hold_done = (32'(r_hold) == 32'(HOLD_PERIODS - 1));

  assign w_on  = (32'(r_cnt) < 32'(r_duty));
  assign w_pat = (r_mode == M_UNISON) ? {N_LED{w_on}} :
                 (w_on ? (N_LED'(1) << r_ch) : '0);

  // NOTE: every register below is assigned with <= so all of them sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_duty        <= '0;
      r_ch          <= '0;
      r_hold        <= '0;
      r_state       <= S_IDLE;
      r_mode        <= M_OFF;
      r_leds        <= OFF_VAL;
      r_period_tick <= 1'b0;
    end else begin
      r_cnt         <= (r_cnt == CNT_W'(PERIOD - 1)) ? '0 : r_cnt + CNT_W'(1);
      r_period_tick <= (r_cnt == CNT_W'(PERIOD - 2));
      r_leds        <= w_force ? OFF_VAL : (w_pat ^ OFF_VAL);

      if (w_force) begin
        r_state <= S_IDLE;
        r_duty  <= '0;
        r_hold  <= '0;
        r_ch    <= '0;
      end else if (w_note) begin
        // A key press restarts the fade immediately, even on a tick cycle.
        r_state <= S_FALL;
        r_duty  <= DUTY_W'(DUTY_MAX);
        r_ch    <= note_idx;
        r_mode  <= M_NOTE;
        r_hold  <= '0;
      end else if (r_period_tick) begin
        case (r_state)
          S_IDLE: begin
            if (mode == M_UNISON || mode == M_CHASE) begin
              r_state <= S_RISE;
              r_duty  <= '0;
              r_ch    <= '0;
              r_mode  <= mode;
            end
          end
          S_RISE: begin
            r_duty <= w_duty_up;
            if (w_duty_up == DUTY_W'(DUTY_MAX)) begin
              r_state <= S_HOLD_HI;
              r_hold  <= '0;
            end
          end
          S_HOLD_HI: begin
            if (w_hold_done) r_state <= S_FALL;
            else             r_hold  <= r_hold + HOLD_W'(1);
          end
          S_FALL: begin
            r_duty <= w_duty_dn;
            if (w_duty_dn == '0) begin
              r_state <= S_HOLD_LO;
              r_hold  <= '0;
            end
          end
          S_HOLD_LO: begin
            if (w_hold_done) begin
              r_mode  <= mode;
              if (mode == M_CHASE) r_ch <= w_ch_next;
              r_state <= (mode == M_NOTE) ? S_IDLE : S_RISE;
            end else begin
              r_hold <= r_hold + HOLD_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign leds        = r_leds;
  assign period_tick = r_period_tick;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_led_breath_scheduler.sv
// Randomized bench for led_breath_scheduler: an envelope-position reference model predicts
// leds/period_tick/busy every cycle; a second N_LED=6 instance covers out-of-range note indices.
module tb_led_breath_scheduler;

  localparam int N     = 4;
  localparam int PER   = 10;
  localparam int DMAX  = 8;
  localparam int STEP  = 2;
  localparam int HP    = 1;
  localparam int RAMP  = (DMAX + STEP - 1) / STEP;  // periods spent ramping each way
  localparam int FALL0 = RAMP + HP;                 // envelope position where the fall begins
  localparam int ENV   = 2 * RAMP + 2 * HP;         // periods per full envelope

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [N-1:0] OFF  = '1;
  localparam logic [5:0]   OFF6 = '1;
`else
  localparam logic [N-1:0] OFF  = '0;
  localparam logic [5:0]   OFF6 = '0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         note_valid;
  logic [1:0]   note_idx;
  logic [N-1:0] leds;
  logic         period_tick;
  logic         busy;

  logic         en6;
  logic [1:0]   mode6;
  logic         nv6;
  logic [2:0]   ni6;
  logic [5:0]   leds6;
  logic         tick6;
  logic         busy6;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: envelope position in periods instead of an explicit state machine.
  int           m_cnt;
  int           m_pos;
  int           m_ch;
  bit           m_active;
  logic [1:0]   m_mode;
  logic [N-1:0] exp_leds;
  bit           exp_tick;

  led_breath_scheduler #(
    .N_LED(N), .PERIOD(PER), .DUTY_MAX(DMAX), .DUTY_STEP(STEP), .HOLD_PERIODS(HP)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .note_valid(note_valid),
    .note_idx(note_idx), .leds(leds), .period_tick(period_tick), .busy(busy)
  );

  led_breath_scheduler #(
    .N_LED(6), .PERIOD(PER), .DUTY_MAX(DMAX), .DUTY_STEP(STEP), .HOLD_PERIODS(HP)
  ) u_dut6 (
    .clk(clk), .rst(rst), .en(en6), .mode(mode6), .note_valid(nv6),
    .note_idx(ni6), .leds(leds6), .period_tick(tick6), .busy(busy6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int duty_at(input int p);
    if (p < RAMP)         return (p * STEP < DMAX) ? p * STEP : DMAX;
    if (p < FALL0)        return DMAX;
    if (p < FALL0 + RAMP) return (DMAX - (p - FALL0) * STEP > 0) ? DMAX - (p - FALL0) * STEP : 0;
    return 0;
  endfunction

  task automatic model_reset();
    m_cnt    = 0;
    m_pos    = 0;
    m_ch     = 0;
    m_active = 0;
    m_mode   = 2'b00;
    exp_leds = OFF;
    exp_tick = 0;
  endtask

  task automatic model_step();
    bit           force_off;
    bit           tick;
    bit           on;
    logic [N-1:0] pat;
    force_off = !en || (mode == 2'b00);
    tick      = (m_cnt == PER - 1);
    on        = m_cnt < (m_active ? duty_at(m_pos) : 0);
    pat       = '0;
    if (on) pat = (m_mode == 2'b01) ? '1 : (N'(1) << m_ch);
    exp_leds  = force_off ? OFF : (pat ^ OFF);
    m_cnt     = (m_cnt + 1) % PER;
    exp_tick  = (m_cnt == PER - 1);
    if (force_off) begin
      m_active = 0;
      m_pos    = 0;
      m_ch     = 0;
    end else if (mode == 2'b11 && note_valid && int'(note_idx) < N) begin
      m_active = 1;
      m_pos    = FALL0;
      m_ch     = int'(note_idx);
      m_mode   = 2'b11;
    end else if (tick) begin
      if (!m_active) begin
        if (mode == 2'b01 || mode == 2'b10) begin
          m_active = 1;
          m_pos    = 0;
          m_ch     = 0;
          m_mode   = mode;
        end
      end else if (m_pos == ENV - 1) begin
        m_mode = mode;
        if (mode == 2'b11) m_active = 0;
        else begin
          if (mode == 2'b10) m_ch = (m_ch + 1) % N;
          m_pos = 0;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("leds", leds, exp_leds);
    check("period_tick", period_tick, exp_tick);
    check("busy", busy, m_active);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int  hits;
    bit  hit;
    rst = 1'b1; en = 1'b0; mode = 2'b00; note_valid = 1'b0; note_idx = '0;
    en6 = 1'b0; mode6 = 2'b00; nv6 = 1'b0; ni6 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_leds", leds, OFF);
    check("reset_busy", busy, 0);
    check("reset_tick", period_tick, 0);
    rst = 1'b0;

    // Unison and chase envelopes.
    en = 1'b1; mode = 2'b01;
    run(3 * ENV * PER);
    mode = 2'b10;
    run(5 * ENV * PER);

    // Note flash with random key presses, including restarts mid-fade.
    mode = 2'b11;
    for (int i = 0; i < 800; i++) begin
      note_valid = ($urandom_range(0, 59) == 0);
      note_idx   = 2'($urandom_range(0, N - 1));
      cycle();
    end
    note_valid = 1'b0;

    // Key press on the very cycle period_tick is high.
    hit = 0;
    for (int i = 0; i < 4 * PER && !hit; i++) begin
      if (m_cnt == PER - 1) hit = 1;
      else cycle();
    end
    check("wait_collision", hit, 1);
    check("collision_tick_now", period_tick, 1);
    note_valid = 1'b1; note_idx = 2'd1;
    cycle();
    note_valid = 1'b0;
    check("collision_full_duty", duty_at(m_pos), DMAX);
    run(ENV * PER);

    // Drop enable during HOLD_HI, then re-enable.
    mode = 2'b01;
    hit  = 0;
    for (int i = 0; i < 4 * ENV * PER && !hit; i++) begin
      if (m_active && m_pos >= RAMP && m_pos < FALL0) hit = 1;
      else cycle();
    end
    check("wait_hold_hi", hit, 1);
    en = 1'b0;
    cycle();
    check("en_drop_leds", leds, OFF);
    check("en_drop_busy", busy, 0);
    en = 1'b1;
    run(2 * ENV * PER);

    // Fully random traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
      en         = ($urandom_range(0, 99) != 0);
      note_valid = ($urandom_range(0, 29) == 0);
      note_idx   = 2'($urandom_range(0, N - 1));
      cycle();
    end
    en = 1'b1; mode = 2'b10; note_valid = 1'b0;
    run(ENV * PER);

    // Asynchronous reset while busy and while period_tick is high.
    hit = 0;
    for (int i = 0; i < 4 * ENV * PER && !hit; i++) begin
      if (m_active && m_cnt == PER - 1) hit = 1;
      else cycle();
    end
    check("wait_reset_point", hit, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_leds", leds, OFF);
    check("async_rst_busy", busy, 0);
    check("async_rst_tick", period_tick, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(2 * ENV * PER);

    // Out-of-range note indices on a 6-LED instance are ignored; index 5 is honoured.
    en6 = 1'b1; mode6 = 2'b11; ni6 = 3'd6; nv6 = 1'b1;
    cycle();
    nv6 = 1'b0;
    check("n6_idx6_busy", busy6, 0);
    ni6 = 3'd7; nv6 = 1'b1;
    cycle();
    nv6 = 1'b0;
    check("n6_idx7_busy", busy6, 0);
    for (int i = 0; i < PER; i++) begin
      cycle();
      check("n6_idle_leds", leds6, OFF6);
    end
    ni6 = 3'd5; nv6 = 1'b1;
    cycle();
    nv6 = 1'b0;
    check("n6_idx5_busy", busy6, 1);
    hits = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      cycle();
      check("n6_other_bits", leds6[4:0], OFF6[4:0]);
      if (leds6[5] != OFF6[5]) hits++;
    end
    check("n6_bit5_pulsed", (hits > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
